// File: rtl/pwm_pkg.sv
// Shared constants for the two-channel PWM register bank: widths, channel
// stride and per-channel register offsets.
package pwm_pkg;
  localparam int NCH       = 2;
  localparam int DW        = 32;
  localparam int CH_STRIDE = 12;

  localparam logic [31:0] REG_ENABLE = 32'd0;
  localparam logic [31:0] REG_PERIOD = 32'd4;
  localparam logic [31:0] REG_DUTY   = 32'd8;
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: enable bit, period/duty registers, counter and outputs.
// With PWM_SHADOW_EN defined, PERIOD/DUTY writes are staged and applied at wrap.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we_en,
  input  logic          i_we_per,
  input  logic          i_we_duty,
  input  logic [DW-1:0] i_wdata,
  output logic          o_en,
  output logic [DW-1:0] o_per_rd,
  output logic [DW-1:0] o_duty_rd,
  output logic          o_pwm,
  output logic          o_period_done
);
  logic          r_en;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_per_a;
  logic [DW-1:0] r_duty_a;
  logic          r_pwm;
  logic          r_pd;
  logic          w_wrap;
  logic          w_stop;

  // per_a <= 1 is handled separately so per_a-1 never underflows
  assign w_wrap = (r_per_a <= DW'(1)) || (r_cnt >= r_per_a - DW'(1));
  assign w_stop = !r_en || (i_we_en && !i_wdata[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else if (i_we_en) begin
      r_en <= i_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pd  <= 1'b0;
    end else if (w_stop) begin
      r_cnt <= '0;
      r_pd  <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_pd  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + DW'(1);
      r_pd  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= r_en && (r_cnt < r_duty_a);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [DW-1:0] r_per_s;
  logic [DW-1:0] r_duty_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_s  <= '0;
      r_duty_s <= '0;
    end else begin
      if (i_we_per)  r_per_s  <= i_wdata;
      if (i_we_duty) r_duty_s <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_a  <= '0;
      r_duty_a <= '0;
    end else if (!r_en || w_wrap) begin
      r_per_a  <= r_per_s;
      r_duty_a <= r_duty_s;
    end
  end

  assign o_per_rd  = r_per_s;
  assign o_duty_rd = r_duty_s;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_a  <= '0;
      r_duty_a <= '0;
    end else begin
      if (i_we_per)  r_per_a  <= i_wdata;
      if (i_we_duty) r_duty_a <= i_wdata;
    end
  end

  assign o_per_rd  = r_per_a;
  assign o_duty_rd = r_duty_a;
`endif

  assign o_en          = r_en;
  assign o_pwm         = r_pwm;
  assign o_period_done = r_pd;
endmodule

// File: rtl/pwm_regbank.sv
// Two-channel PWM register bank: address decode, per-channel write enables,
// read mux and registered read data. Optional PWM_SHADOW_EN lives in pwm_channel.
module pwm_regbank
  import pwm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [31:0]    adr,
  input  logic           cs,
  input  logic           wr,
  input  logic           rd,
  input  logic [DW-1:0]  d_in,
  output logic [DW-1:0]  d_out,
  output logic [NCH-1:0] pwm_out,
  output logic [NCH-1:0] period_done
);
  logic           w_wr;
  logic           w_rd;
  logic [NCH-1:0] w_hit_en;
  logic [NCH-1:0] w_hit_per;
  logic [NCH-1:0] w_hit_duty;
  logic [NCH-1:0] w_en;
  logic [DW-1:0]  w_per_rd  [NCH];
  logic [DW-1:0]  w_duty_rd [NCH];
  logic [DW-1:0]  w_rd_data;
  logic [DW-1:0]  r_d_out;

  // a simultaneous write suppresses the read
  assign w_wr = cs && wr;
  assign w_rd = cs && rd && !wr;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [31:0] BASE = 32'(c * CH_STRIDE);

    assign w_hit_en[c]   = (adr == BASE + REG_ENABLE);
    assign w_hit_per[c]  = (adr == BASE + REG_PERIOD);
    assign w_hit_duty[c] = (adr == BASE + REG_DUTY);

    pwm_channel u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_we_en       (w_wr && w_hit_en[c]),
      .i_we_per      (w_wr && w_hit_per[c]),
      .i_we_duty     (w_wr && w_hit_duty[c]),
      .i_wdata       (d_in),
      .o_en          (w_en[c]),
      .o_per_rd      (w_per_rd[c]),
      .o_duty_rd     (w_duty_rd[c]),
      .o_pwm         (pwm_out[c]),
      .o_period_done (period_done[c])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_hit_en[i])   w_rd_data = DW'(w_en[i]);
      if (w_hit_per[i])  w_rd_data = w_per_rd[i];
      if (w_hit_duty[i]) w_rd_data = w_duty_rd[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      r_d_out <= w_rd_data;
    end
  end

  assign d_out = r_d_out;
endmodule

// File: tb/tb_pwm_regbank.sv
// Directed bench for pwm_regbank: register read-back table plus hand-written
// waveform, mid-period, disable and reset sequences.
module tb_pwm_regbank;
  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic [1:0]  pwm_out;
  logic [1:0]  period_done;

  int total;
  int bad;

  typedef struct {
    logic        do_wr;
    logic [31:0] wadr;
    logic [31:0] wdata;
    logic [31:0] radr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  pwm_regbank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adr         (adr),
    .cs          (cs),
    .wr          (wr),
    .rd          (rd),
    .d_in        (d_in),
    .d_out       (d_out),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; adr = a; d_in = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; adr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  initial begin
    logic [31:0] rv;
    total = 0;
    bad   = 0;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; adr = '0; d_in = '0;

    tbl[0]  = '{1'b1, 32'd8,  32'd230000,     32'd8,  32'd230000};
    tbl[1]  = '{1'b1, 32'd4,  32'd10,         32'd4,  32'd10};
    tbl[2]  = '{1'b1, 32'd0,  32'hFFFF_FFFE,  32'd0,  32'd0};
    tbl[3]  = '{1'b1, 32'd0,  32'd3,          32'd0,  32'd1};
    tbl[4]  = '{1'b1, 32'd16, 32'd7,          32'd16, 32'd7};
    tbl[5]  = '{1'b1, 32'd20, 32'hDEAD_BEEF,  32'd20, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b1, 32'd12, 32'd2,          32'd12, 32'd0};
    tbl[7]  = '{1'b1, 32'd2,  32'd5,          32'd2,  32'd0};
    tbl[8]  = '{1'b0, 32'd0,  32'd0,          32'd24, 32'd0};
    tbl[9]  = '{1'b1, 32'd6,  32'd99,         32'd4,  32'd10};
    tbl[10] = '{1'b1, 32'd24, 32'd1,          32'd0,  32'd1};
    tbl[11] = '{1'b1, 32'd0,  32'd0,          32'd0,  32'd0};

    #13;
    chk("rst_dout", d_out, 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_pd", 32'(period_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_reg(32'd4, rv);
    chk("rst_rd_per0", rv, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_wr) wr_reg(tbl[i].wadr, tbl[i].wdata);
      rd_reg(tbl[i].radr, rv);
      chk($sformatf("tbl_rd[%0d]", i), rv, tbl[i].exp);
    end
    wr_reg(32'd12, 32'd0);

    // write and read together: write lands, d_out must hold
    cs = 1'b1; wr = 1'b1; rd = 1'b1; adr = 32'd8; d_in = 32'd55;
    tick();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    chk("wr_rd_no_read", d_out, 32'd0);
    rd_reg(32'd8, rv);
    chk("wr_rd_write_won", rv, 32'd55);

    // channel 0: period 10, duty 3
    wr_reg(32'd4, 32'd10);
    wr_reg(32'd8, 32'd3);
    wr_reg(32'd0, 32'd1);
    chk("en_edge_pwm0", 32'(pwm_out[0]), 32'd0);
    for (int k = 0; k < 38; k++) begin
      tick();
      chk($sformatf("wave_pwm0[%0d]", k), 32'(pwm_out[0]), 32'((k % 10) < 3));
      chk($sformatf("wave_pd0[%0d]", k), 32'(period_done[0]), 32'((k % 10) == 9));
      chk($sformatf("wave_pwm1[%0d]", k), 32'(pwm_out[1]), 32'd0);
    end

    // cnt is 8 here; shrink period to 6
    wr_reg(32'd4, 32'd6);
    chk("mid_pwm0", 32'(pwm_out[0]), 32'd0);
    chk("mid_pd0", 32'(period_done[0]), 32'd0);
    tick();
    chk("mid_wrap_pd0", 32'(period_done[0]), 32'd1);
    chk("mid_wrap_pwm0", 32'(pwm_out[0]), 32'd0);
    for (int j = 0; j < 12; j++) begin
      tick();
      chk($sformatf("p6_pwm0[%0d]", j), 32'(pwm_out[0]), 32'((j % 6) < 3));
      chk($sformatf("p6_pd0[%0d]", j), 32'(period_done[0]), 32'((j % 6) == 5));
    end

    // duty = period: constant high; then disable at cnt=5
    wr_reg(32'd8, 32'd6);
    chk("d6_pwm0", 32'(pwm_out[0]), 32'd1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("d6_pwm0[%0d]", j), 32'(pwm_out[0]), 32'd1);
      chk($sformatf("d6_pd0[%0d]", j), 32'(period_done[0]), 32'd0);
    end
    wr_reg(32'd0, 32'd0);
    chk("dis_edge_pwm0", 32'(pwm_out[0]), 32'd1);
    chk("dis_edge_pd0", 32'(period_done[0]), 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("dis_pwm0[%0d]", j), 32'(pwm_out[0]), 32'd0);
      chk($sformatf("dis_pd0[%0d]", j), 32'(period_done[0]), 32'd0);
    end
    wr_reg(32'd0, 32'd1);
    chk("reen_edge_pwm0", 32'(pwm_out[0]), 32'd0);
    for (int j = 0; j < 12; j++) begin
      tick();
      chk($sformatf("reen_pwm0[%0d]", j), 32'(pwm_out[0]), 32'd1);
      chk($sformatf("reen_pd0[%0d]", j), 32'(period_done[0]), 32'((j % 6) == 5));
    end

    // channel 1: period 4, duty 4 then duty 0
    wr_reg(32'd16, 32'd4);
    wr_reg(32'd20, 32'd4);
    wr_reg(32'd12, 32'd1);
    chk("ch1_en_edge", 32'(pwm_out[1]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("ch1_hi_pwm[%0d]", k), 32'(pwm_out[1]), 32'd1);
      chk($sformatf("ch1_hi_pd[%0d]", k), 32'(period_done[1]), 32'((k % 4) == 3));
    end
    wr_reg(32'd20, 32'd0);
    chk("ch1_d0_edge", 32'(pwm_out[1]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("ch1_lo_pwm[%0d]", k), 32'(pwm_out[1]), 32'd0);
      chk($sformatf("ch1_lo_pd[%0d]", k), 32'(period_done[1]), 32'((k % 4) == 2));
    end

    // asynchronous reset mid-period
    rd_reg(32'd4, rv);
    chk("pre_rst_rd", rv, 32'd6);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'd0);
    chk("arst_pd", 32'(period_done), 32'd0);
    chk("arst_dout", d_out, 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("inrst_pd[%0d]", j), 32'(period_done), 32'd0);
      chk($sformatf("inrst_pwm[%0d]", j), 32'(pwm_out), 32'd0);
    end
    rst_n = 1'b1;
    rd_reg(32'd4, rv);
    chk("post_rst_per0", rv, 32'd0);
    rd_reg(32'd12, rv);
    chk("post_rst_en1", rv, 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_rst_pwm[%0d]", j), 32'(pwm_out), 32'd0);
      chk($sformatf("post_rst_pd[%0d]", j), 32'(period_done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
